// File: rtl/spu_cache_mp_if.sv
// Command/response bundle for spu_cache_mp: two independent access ports plus clear control.
interface spu_cache_mp_if #(
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned LANES      = 64,
    parameter int unsigned ADDR_WIDTH = 9
);
    localparam int unsigned W = ELEM_WIDTH * LANES;

    logic                  clr_req;
    logic                  ready;
    logic                  cmd_dropped;

    logic                  a_en;
    logic                  a_we;
    logic [LANES-1:0]      a_mask;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [W-1:0]          a_din;
    logic [W-1:0]          a_dout;
    logic                  a_rvalid;

    logic                  b_en;
    logic                  b_we;
    logic [LANES-1:0]      b_mask;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [W-1:0]          b_din;
    logic [W-1:0]          b_dout;
    logic                  b_rvalid;

    modport master (
        output clr_req, a_en, a_we, a_mask, a_addr, a_din,
               b_en, b_we, b_mask, b_addr, b_din,
        input  ready, cmd_dropped, a_dout, a_rvalid, b_dout, b_rvalid
    );

    modport slave (
        input  clr_req, a_en, a_we, a_mask, a_addr, a_din,
               b_en, b_we, b_mask, b_addr, b_din,
        output ready, cmd_dropped, a_dout, a_rvalid, b_dout, b_rvalid
    );
endinterface

// File: rtl/spu_cache_mp.sv
// True dual-port masked scratchpad with port-A-wins collision policy, read-first reads,
// 1- or 2-cycle read latency and a zero-clear engine that runs after reset or on request.
module spu_cache_mp #(
    parameter int unsigned ELEM_WIDTH   = 16,
    parameter int unsigned LANES        = 64,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spu_cache_mp_if.slave bus
);
    localparam int unsigned W     = ELEM_WIDTH * LANES;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_d;

    logic ready_d;
    logic drop_c;
    logic clr_we_c;
    logic a_wr_c;
    logic b_wr_c;
    logic a_rd_c;
    logic b_rd_c;

    logic [W-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: sweep every address once, then serve commands until a clear request
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == '1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Output/control decode; bus.ready mirrors state_q and gates command acceptance
    always_comb begin
        ready_d  = 1'b0;
        clr_we_c = 1'b0;
        ready_d  = (state_d == ST_READY);
        clr_we_c = (state_q == ST_CLEAR);
        drop_c   = (bus.a_en | bus.b_en) & ~bus.ready;
        a_wr_c   = bus.ready & bus.a_en &  bus.a_we;
        b_wr_c   = bus.ready & bus.b_en &  bus.b_we;
        a_rd_c   = bus.ready & bus.a_en & ~bus.a_we;
        b_rd_c   = bus.ready & bus.b_en & ~bus.b_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ready       <= 1'b0;
            bus.cmd_dropped <= 1'b0;
        end else begin
            bus.ready       <= ready_d;
            bus.cmd_dropped <= drop_c;
        end
    end

    // Array write: B first so A's later assignment takes overlapping lanes on a collision
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_cnt_q] <= '0;
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            if (b_wr_c && bus.b_mask[i]) begin
                mem[bus.b_addr][i*ELEM_WIDTH +: ELEM_WIDTH] <= bus.b_din[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
            if (a_wr_c && bus.a_mask[i]) begin
                mem[bus.a_addr][i*ELEM_WIDTH +: ELEM_WIDTH] <= bus.a_din[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bus.a_dout   <= '0;
                bus.b_dout   <= '0;
                bus.a_rvalid <= 1'b0;
                bus.b_rvalid <= 1'b0;
            end else begin
                bus.a_rvalid <= a_rd_c;
                bus.b_rvalid <= b_rd_c;
                if (a_rd_c) bus.a_dout <= mem[bus.a_addr];
                if (b_rd_c) bus.b_dout <= mem[bus.b_addr];
            end
        end
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic [W-1:0] a_rd_q;
        logic [W-1:0] b_rd_q;
        logic         a_vld_q;
        logic         b_vld_q;

        // One pipeline stage between the array and dout; runs regardless of FSM state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_rd_q       <= '0;
                b_rd_q       <= '0;
                a_vld_q      <= 1'b0;
                b_vld_q      <= 1'b0;
                bus.a_dout   <= '0;
                bus.b_dout   <= '0;
                bus.a_rvalid <= 1'b0;
                bus.b_rvalid <= 1'b0;
            end else begin
                a_vld_q      <= a_rd_c;
                b_vld_q      <= b_rd_c;
                if (a_rd_c) a_rd_q <= mem[bus.a_addr];
                if (b_rd_c) b_rd_q <= mem[bus.b_addr];
                bus.a_rvalid <= a_vld_q;
                bus.b_rvalid <= b_vld_q;
                if (a_vld_q) bus.a_dout <= a_rd_q;
                if (b_vld_q) bus.b_dout <= b_rd_q;
            end
        end
    end else begin : g_bad_latency
        $fatal(1, "spu_cache_mp: READ_LATENCY must be 1 or 2");
    end
endmodule

// File: tb/tb_spu_cache_mp.sv
// Drives a latency-1 and a latency-2 instance with identical stimulus and scoreboards both.
module tb_spu_cache_mp;
    localparam int unsigned EW = 8;
    localparam int unsigned LN = 4;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [3:0]  mask;
        logic [2:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } cmd_t;

    typedef struct packed {
        cmd_t a;
        cmd_t b;
        logic clr;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic ready_m;
    int   clr_left;
    exp_t sb [4][$];
    logic [31:0] last [4];
    vec_t vt [$];

    spu_cache_mp_if #(.ELEM_WIDTH(EW), .LANES(LN), .ADDR_WIDTH(AW)) bus1 ();
    spu_cache_mp_if #(.ELEM_WIDTH(EW), .LANES(LN), .ADDR_WIDTH(AW)) bus2 ();

    spu_cache_mp #(.ELEM_WIDTH(EW), .LANES(LN), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    spu_cache_mp #(.ELEM_WIDTH(EW), .LANES(LN), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response checker: data, arrival cycle, no unexpected pulses, dout holds otherwise
    task automatic chk_port(input int p, input logic rv, input logic [31:0] d);
        exp_t e;
        checks++;
        if (rv) begin
            if (sb[p].size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected port%0d got data %h at cycle %0d", p, d, cyc);
            end else begin
                e = sb[p].pop_front();
                if (d !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read_data port%0d got %h at cycle %0d expected %h at cycle %0d",
                             p, d, cyc, e.data, e.due);
                end
            end
            last[p] = d;
        end else begin
            if (d !== last[p]) begin
                errors++;
                $display("FAIL dout_hold port%0d got %h expected %h", p, d, last[p]);
            end
            if (sb[p].size() != 0 && sb[p][0].due <= cyc) begin
                errors++;
                $display("FAIL rvalid_missing port%0d got none expected %h at cycle %0d",
                         p, sb[p][0].data, sb[p][0].due);
                void'(sb[p].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk_port(0, bus1.a_rvalid, bus1.a_dout);
            chk_port(1, bus1.b_rvalid, bus1.b_dout);
            chk_port(2, bus2.a_rvalid, bus2.a_dout);
            chk_port(3, bus2.b_rvalid, bus2.b_dout);
        end
    end

    function automatic cmd_t rd(input logic [2:0] ad, input logic [31:0] e);
        cmd_t c;
        c      = '0;
        c.en   = 1'b1;
        c.addr = ad;
        c.exp  = e;
        return c;
    endfunction

    function automatic cmd_t wr(input logic [2:0] ad, input logic [3:0] m, input logic [31:0] d);
        cmd_t c;
        c      = '0;
        c.en   = 1'b1;
        c.we   = 1'b1;
        c.mask = m;
        c.addr = ad;
        c.din  = d;
        return c;
    endfunction

    function automatic vec_t mkv(input cmd_t a, input cmd_t b, input logic clr);
        vec_t v;
        v.a   = a;
        v.b   = b;
        v.clr = clr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus1.clr_req = v.clr;
        bus1.a_en = v.a.en;  bus1.a_we = v.a.we;  bus1.a_mask = v.a.mask;
        bus1.a_addr = v.a.addr;  bus1.a_din = v.a.din;
        bus1.b_en = v.b.en;  bus1.b_we = v.b.we;  bus1.b_mask = v.b.mask;
        bus1.b_addr = v.b.addr;  bus1.b_din = v.b.din;
        bus2.clr_req = v.clr;
        bus2.a_en = v.a.en;  bus2.a_we = v.a.we;  bus2.a_mask = v.a.mask;
        bus2.a_addr = v.a.addr;  bus2.a_din = v.a.din;
        bus2.b_en = v.b.en;  bus2.b_we = v.b.we;  bus2.b_mask = v.b.mask;
        bus2.b_addr = v.b.addr;  bus2.b_din = v.b.din;
    endtask

    // One command edge: push expectations, advance the ready model, check control outputs
    task automatic step(input vec_t v);
        logic rdy0;
        logic exp_drop;
        rdy0     = ready_m;
        exp_drop = (v.a.en | v.b.en) & ~rdy0;
        drive(v);
        if (rdy0) begin
            if (v.a.en && !v.a.we) begin
                sb[0].push_back('{v.a.exp, cyc + 1});
                sb[2].push_back('{v.a.exp, cyc + 2});
            end
            if (v.b.en && !v.b.we) begin
                sb[1].push_back('{v.b.exp, cyc + 1});
                sb[3].push_back('{v.b.exp, cyc + 2});
            end
            if (v.clr) begin
                ready_m  = 1'b0;
                clr_left = 8;
            end
        end else begin
            clr_left--;
            if (clr_left == 0) ready_m = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("ready_l1", 32'(bus1.ready), 32'(ready_m));
        chk("ready_l2", 32'(bus2.ready), 32'(ready_m));
        chk("cmd_dropped_l1", 32'(bus1.cmd_dropped), 32'(exp_drop));
        chk("cmd_dropped_l2", 32'(bus2.cmd_dropped), 32'(exp_drop));
        drive('0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready_l1", 32'(bus1.ready), 32'd0);
        chk("rst_ready_l2", 32'(bus2.ready), 32'd0);
        chk("rst_drop_l1", 32'(bus1.cmd_dropped), 32'd0);
        chk("rst_drop_l2", 32'(bus2.cmd_dropped), 32'd0);
        chk("rst_rvalid_l1", 32'({bus1.a_rvalid, bus1.b_rvalid}), 32'd0);
        chk("rst_rvalid_l2", 32'({bus2.a_rvalid, bus2.b_rvalid}), 32'd0);
        chk("rst_adout_l1", bus1.a_dout, 32'd0);
        chk("rst_bdout_l1", bus1.b_dout, 32'd0);
        chk("rst_adout_l2", bus2.a_dout, 32'd0);
        chk("rst_bdout_l2", bus2.b_dout, 32'd0);
        for (int p = 0; p < 4; p++) begin
            sb[p].delete();
            last[p] = '0;
        end
        ready_m  = 1'b0;
        clr_left = 8;
        drive('0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam cmd_t NOP = '0;

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive('0);
        for (int p = 0; p < 4; p++) last[p] = '0;

        do_reset();
        // Clear sweep after reset: eight idle edges, ready rises on the last
        for (int i = 0; i < 8; i++) vt.push_back(mkv(NOP, NOP, 1'b0));
        for (int i = 0; i < 8; i++) vt.push_back(mkv(rd(3'(i), 32'h0), rd(3'(7 - i), 32'h0), 1'b0));
        vt.push_back(mkv(wr(3'd5, 4'b1111, 32'h11223344), NOP, 1'b0));
        vt.push_back(mkv(wr(3'd5, 4'b0101, 32'hAABBCCDD), NOP, 1'b0));
        vt.push_back(mkv(rd(3'd5, 32'h11BB33DD), NOP, 1'b0));
        vt.push_back(mkv(wr(3'd2, 4'b0011, 32'h01010101), wr(3'd2, 4'b0110, 32'h02020202), 1'b0));
        vt.push_back(mkv(rd(3'd2, 32'h00020101), wr(3'd2, 4'b0000, 32'hFFFFFFFF), 1'b0));
        vt.push_back(mkv(rd(3'd2, 32'h00020101), NOP, 1'b0));
        vt.push_back(mkv(wr(3'd3, 4'b1111, 32'hFFFFFFFF), rd(3'd3, 32'h0), 1'b0));
        vt.push_back(mkv(rd(3'd5, 32'h11BB33DD), rd(3'd3, 32'hFFFFFFFF), 1'b0));
        vt.push_back(mkv(rd(3'd0, 32'h0), NOP, 1'b0));
        vt.push_back(mkv(rd(3'd1, 32'h0), NOP, 1'b0));
        vt.push_back(mkv(rd(3'd2, 32'h00020101), NOP, 1'b0));
        vt.push_back(mkv(rd(3'd3, 32'hFFFFFFFF), NOP, 1'b0));
        // Clear request: commands on that edge still execute, then eight dropped-window edges
        vt.push_back(mkv(rd(3'd5, 32'h11BB33DD), wr(3'd6, 4'b1111, 32'h12345678), 1'b1));
        vt.push_back(mkv(rd(3'd1, 32'h0), wr(3'd4, 4'b1111, 32'hDEADBEEF), 1'b0));
        vt.push_back(mkv(NOP, NOP, 1'b1));
        for (int i = 0; i < 5; i++) vt.push_back(mkv(NOP, NOP, 1'b0));
        vt.push_back(mkv(rd(3'd7, 32'h0), NOP, 1'b0));
        for (int i = 0; i < 8; i++) vt.push_back(mkv(rd(3'(i), 32'h0), rd(3'(i), 32'h0), 1'b0));

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        // Reset in the middle of a clear restarts a full eight-edge sweep
        step(mkv(wr(3'd3, 4'b1111, 32'hCAFEF00D), NOP, 1'b0));
        step(mkv(rd(3'd3, 32'hCAFEF00D), NOP, 1'b1));
        repeat (3) step(mkv(NOP, NOP, 1'b0));
        do_reset();
        for (int i = 0; i < 8; i++) step(mkv(NOP, rd(3'd0, 32'h0), 1'b0));
        step(mkv(rd(3'd3, 32'h0), rd(3'd6, 32'h0), 1'b0));

        // Reset lands while the latency-2 read is still in its pipeline stage
        step(mkv(wr(3'd1, 4'b1111, 32'h5A5A5A5A), NOP, 1'b0));
        step(mkv(rd(3'd1, 32'h5A5A5A5A), NOP, 1'b0));
        do_reset();
        for (int i = 0; i < 8; i++) step(mkv(NOP, NOP, 1'b0));
        step(mkv(rd(3'd1, 32'h0), NOP, 1'b0));

        repeat (3) step(mkv(NOP, NOP, 1'b0));
        for (int p = 0; p < 4; p++) chk($sformatf("drain_port%0d", p), 32'(sb[p].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
